neuron_mac_seq: RTL and testbench
=================================

# neuron_mac_seq

Sequencer for one 16-tap neuron of the SPI-ADC inference path. It collects a window of ADC samples into a local buffer and walks an external combinational weight ROM through its address range. Each cycle it multiply-accumulates one sample by the weight read back. It presents the dot product on a valid/ready output port. The block sits between the SPI ADC sample stream and the activation/output stage; the weight ROM is instantiated beside it and driven only by this block's `rom_addr`.

## Interface
- `DATA_W`, 8: width of samples and of ROM weights. Both are unsigned.
- `ADDR_W`, 4: ROM address width. Window length N = 2^ADDR_W (16).
- Derived, not overridable: `ACC_W` = 2*DATA_W + ADDR_W (20).
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clr`  in  1  synchronous abort back to FILL. Discards buffer and accumulator.
- `sample_valid`  in  1  ADC sample available.
- `sample_data`  in  DATA_W  ADC sample, unsigned.
- `sample_ready`  out  1  block can accept a sample.
- `rom_addr`  out  ADDR_W  weight ROM address, registered.
- `rom_data`  in  DATA_W  weight at `rom_addr`, combinational, valid in the same cycle.
- `result_valid`  out  1  `result` holds a completed dot product.
- `result`  out  ACC_W  sum over i=0..N-1 of `sample[i]*weight[i]`.
- `result_ready`  in  1  downstream accepts `result`.
- `busy`  out  1  high in MAC and DONE.

## Operation
- Sample buffer: N x DATA_W registers. Write pointer `wr_ptr` is ADDR_W bits. MAC index `idx` is ADDR_W bits and drives `rom_addr` directly.
- **FILL** (reset state)
  - `sample_ready`=1.
  - On `sample_valid`&`sample_ready`: `buf[wr_ptr]`<=`sample_data` and `wr_ptr`++.
  - When the accepted sample has `wr_ptr`==N-1: `wr_ptr`<=0, `idx`<=0, `acc`<=0, then go to MAC.
  - `rom_addr` is held at 0.
- **MAC**
  - `sample_ready`=0.
  - Each cycle: `acc` <= `acc` + `buf[idx]`*`rom_data`, then `idx`++.
  - At `idx`==N-1: `result` <= `acc` + `buf[N-1]`*`rom_data`, `result_valid`<=1, `idx`<=0, then go to DONE.
  - Arithmetic: unsigned, full precision, no saturation. The worst case (N*(2^DATA_W-1)^2 = 1,040,400) fits in ACC_W.
- **DONE**
  - `sample_ready`=0. `result` and `result_valid` are held stable.
  - On `result_valid`&`result_ready`: `result_valid`<=0, then go to FILL.
  - `result` keeps its last value after the handshake.
- **Reset and abort values**
  - `clr`=1 in any state: next state FILL; `wr_ptr`, `idx`, `acc`, `rom_addr` <= 0; `result_valid`<=0.
  - `result` is unchanged by `clr`. Buffer contents are don't-care.
  - `clr` has priority over a simultaneous sample or result handshake; that sample is dropped.
- Asynchronous reset (`rst_n`=0) at any point, including mid-MAC:
  - Outputs: `sample_ready`=1, `rom_addr`=0, `result_valid`=0, `result`=0, `busy`=0.
  - Internal: state FILL, `wr_ptr`=0, `idx`=0, `acc`=0.
- `sample_valid` while `sample_ready`=0 is ignored. The upstream holds or drops the sample by its own rule.

## Timing
- `sample_ready`, `busy` and `result_valid` are decoded from the state register, with no combinational path from inputs.
- **Latency:** if the N-th sample is accepted at edge T, MAC occupies the cycles after edges T..T+N-1, and `result_valid` rises after edge T+N (16 cycles).
- **ROM address timing:** `rom_addr` is k in the k-th MAC cycle (k=0..N-1). `rom_data` is consumed in that same cycle.
- **Handshake timing:**
  - With `result_ready` tied high, `result_valid` is high for exactly 1 cycle.
  - `sample_ready` returns high the cycle after the result handshake.
  - Minimum period per window: N fill + N MAC + 1 DONE = 33 cycles.
- **Backpressure:** `result_ready` low holds DONE indefinitely. No sample is accepted and no result is lost.
- **Gaps:** gaps in `sample_valid` during FILL only stretch FILL. `wr_ptr` does not advance without a handshake.

## Test plan
- **Basic dot product:** bench ROM returns addr+1; 16 samples all =1 with `result_ready`=1. Required: `rom_addr` steps 0..15 on consecutive cycles, `result`=136, `result_valid` high for 1 cycle, exactly 16 cycles after the last sample.
- **Width corner:** ROM constant 255; samples all 255. Required: `result`=1,040,400 (0xFE010), no wrap.
- **Backpressure and gaps:** samples 0..15 with random `sample_valid` gaps; ROM=1; `result_ready` held low for 10 cycles. Required: `result`=120 held stable; `sample_ready`=0 throughout; the handshake returns the block to FILL the next cycle.
- **Abort mid-MAC:** `clr` pulsed at MAC cycle 7, followed by a fresh window of samples =2 with ROM=addr+1. Required: no `result_valid` for the aborted window; the next `result`=272.
- **Reset mid-operation:** `rst_n` low during MAC. Required: outputs go immediately to reset values (`result`=0, `sample_ready`=1, `rom_addr`=0); a full window afterwards gives the correct `result`.
- **Simultaneous events:** `clr` asserted on the same edge as the 16th sample handshake. Required: the sample is dropped, the state stays FILL, `wr_ptr`=0.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Purpose : one 16-tap neuron. Buffers a window of ADC samples, then multiply-accumulates them
//           against an external combinational weight ROM that this block addresses.
// Latency : the dot product is valid N cycles after the N-th sample is accepted. A window takes at least 2N+1 cycles.
// Backpr. : result_ready_i low holds DONE indefinitely. No sample is accepted and no result is lost.
//
// Ports
//   clk_i, rst_ni        single clock, asynchronous active-low reset
//   clr_i                synchronous abort back to FILL. Drops the buffer and the accumulator.
//   sample_*_i/_o        valid/ready ADC sample input (unsigned)
//   rom_addr_o           registered weight address; rom_data_i is read back in the same cycle
//   result_*_o/_i        valid/ready dot-product output
//   busy_o               high while in MAC or DONE
module neuron_mac_seq #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 4,
    localparam int ACC_W  = 2 * DATA_W + ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_data_i,
    output logic              sample_ready_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              result_valid_o,
    output logic [ACC_W-1:0]  result_o,
    input  logic              result_ready_i,
    output logic              busy_o
);

    localparam int N = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    result_q, result_d;
    logic [DATA_W-1:0]   smp_buf_q [N];
    logic                buf_we;

    // Zero-extend both operands before multiplying so that the product is full-precision.
    logic [2*DATA_W-1:0] samp_ext;
    logic [2*DATA_W-1:0] weight_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    mac_sum;

    assign samp_ext   = {{DATA_W{1'b0}}, smp_buf_q[idx_q]};
    assign weight_ext = {{DATA_W{1'b0}}, rom_data_i};
    assign prod       = samp_ext * weight_ext;
    assign mac_sum    = acc_q + {{ADDR_W{1'b0}}, prod};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. An abort overrides every transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (sample_valid_i && (&wr_ptr_q)) state_d = ST_MAC;
            ST_MAC:  if (&idx_q)                        state_d = ST_DONE;
            ST_DONE: if (result_ready_i)                state_d = ST_FILL;
            default:                                    state_d = ST_FILL;
        endcase
        if (clr_i) begin
            state_d = ST_FILL;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. These are decoded from the state only, so no input reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        sample_ready_o = (state_q == ST_FILL);
        result_valid_o = (state_q == ST_DONE);
        busy_o         = (state_q == ST_MAC) || (state_q == ST_DONE);
    end

    // idx_q is 0 outside MAC, so it can drive the ROM address directly.
    assign rom_addr_o = idx_q;
    assign result_o   = result_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        buf_we   = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (sample_valid_i) begin
                    buf_we   = 1'b1;
                    // The pointer wraps to 0 on the last sample of the window.
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (&wr_ptr_q) begin
                        idx_d = '0;
                        acc_d = '0;
                    end
                end
            end
            ST_MAC: begin
                acc_d = mac_sum;
                // The index wraps to 0 after the last tap, which leaves rom_addr at 0 for DONE and FILL.
                idx_d = idx_q + ADDR_W'(1);
                if (&idx_q) begin
                    result_d = mac_sum;
                end
            end
            default: ;
        endcase

        // An abort drops the in-flight window and any simultaneous sample. The last result is kept.
        if (clr_i) begin
            wr_ptr_d = '0;
            idx_d    = '0;
            acc_d    = '0;
            result_d = result_q;
            buf_we   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // The sample storage has no reset. Its contents are always overwritten before the MAC reads them.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            smp_buf_q[wr_ptr_q] <= sample_data_i;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 2 * DATA_W + ADDR_W;
    localparam int N      = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sample_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              result_valid;
    logic [ACC_W-1:0]  result;
    logic              result_ready;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Bench weight ROM: 0 -> addr+1, 1 -> constant 255, 2 -> constant 1
    int rom_mode = 0;
    always_comb begin
        case (rom_mode)
            0:       rom_data = DATA_W'(rom_addr) + 8'd1;
            1:       rom_data = 8'd255;
            default: rom_data = 8'd1;
        endcase
    end

    neuron_mac_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr),
        .sample_valid_i (sample_valid),
        .sample_data_i  (sample_data),
        .sample_ready_o (sample_ready),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .result_valid_o (result_valid),
        .result_o       (result),
        .result_ready_i (result_ready),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and wait (bounded) until it is accepted. The call returns at #1 after the accepting edge.
    task automatic send_sample(input logic [DATA_W-1:0] v);
        int n = 0;
        sample_data  = v;
        sample_valid = 1'b1;
        while (!sample_ready && n < 100) begin
            tick();
            n++;
        end
        if (!sample_ready) check("send_timeout", 32'd0, 32'd1);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_window(input logic [DATA_W-1:0] v);
        for (int i = 0; i < N; i++) send_sample(v);
    endtask

    // Count the cycles from the last accepted sample until result_valid rises (bounded).
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 64) begin
            tick();
            cyc++;
        end
        if (!result_valid) check("result_timeout", 32'd0, 32'd1);
    endtask

    int cyc;

    initial begin
        rst_n        = 1'b0;
        clr          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        result_ready = 1'b1;
        #1;
        check("rst_sample_ready", 32'(sample_ready), 32'd1);
        check("rst_rom_addr",     32'(rom_addr),     32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result",       32'(result),       32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        #13 rst_n = 1'b1;
        tick();

        // ---- Basic dot product: samples 1, ROM addr+1 -> 136 ----
        rom_mode = 0;
        send_window(8'd1);
        for (int k = 0; k < N; k++) begin
            check("basic_rom_addr", 32'(rom_addr), 32'(k));
            check("basic_busy", 32'(busy), 32'd1);
            check("basic_no_valid", 32'(result_valid), 32'd0);
            tick();
        end
        check("basic_valid", 32'(result_valid), 32'd1);
        check("basic_result", 32'(result), 32'd136);
        check("basic_rdy_low", 32'(sample_ready), 32'd0);
        tick();
        check("basic_valid_1cyc", 32'(result_valid), 32'd0);
        check("basic_ready_back", 32'(sample_ready), 32'd1);
        check("basic_result_kept", 32'(result), 32'd136);

        // ---- Width corner: 255 * 255 * 16 = 1,040,400 ----
        rom_mode = 1;
        send_window(8'd255);
        wait_result(cyc);
        check("corner_latency", 32'(cyc), 32'd16);
        check("corner_result", 32'(result), 32'h000FE010);
        tick();

        // ---- Backpressure and gaps: samples 0..15, ROM 1 -> 120 ----
        rom_mode     = 2;
        result_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            send_sample(DATA_W'(i));
        end
        wait_result(cyc);
        check("bp_latency", 32'(cyc), 32'd16);
        sample_valid = 1'b1;
        sample_data  = 8'd99;
        for (int c = 0; c < 10; c++) begin
            check("bp_result_held", 32'(result), 32'd120);
            check("bp_valid_held", 32'(result_valid), 32'd1);
            check("bp_sample_ready", 32'(sample_ready), 32'd0);
            tick();
        end
        sample_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        check("bp_valid_drop", 32'(result_valid), 32'd0);
        check("bp_fill_next", 32'(sample_ready), 32'd1);

        // ---- Abort mid-MAC: clr at MAC cycle 7, then samples 2 -> 272 ----
        rom_mode = 0;
        send_window(8'd3);
        for (int k = 0; k < 7; k++) tick();
        check("abort_at_cycle7", 32'(rom_addr), 32'd7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_fill", 32'(sample_ready), 32'd1);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result_kept", 32'(result), 32'd120);
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (result_valid) seen++;
                tick();
            end
            check("abort_no_valid", 32'(seen), 32'd0);
        end
        send_window(8'd2);
        wait_result(cyc);
        check("abort_next_latency", 32'(cyc), 32'd16);
        check("abort_next_result", 32'(result), 32'd272);
        tick();

        // ---- Reset mid-MAC, then samples 4 -> 544 ----
        send_window(8'd5);
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_result", 32'(result), 32'd0);
        check("arst_sample_ready", 32'(sample_ready), 32'd1);
        check("arst_rom_addr", 32'(rom_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_window(8'd4);
        wait_result(cyc);
        check("arst_next_latency", 32'(cyc), 32'd16);
        check("arst_next_result", 32'(result), 32'd544);
        tick();

        // ---- clr coincident with the 16th sample handshake ----
        for (int i = 0; i < N - 1; i++) send_sample(8'd7);
        sample_data  = 8'd7;
        sample_valid = 1'b1;
        clr          = 1'b1;
        tick();
        sample_valid = 1'b0;
        clr          = 1'b0;
        check("simul_stay_fill", 32'(sample_ready), 32'd1);
        check("simul_busy", 32'(busy), 32'd0);
        // A full fresh window must be needed: MAC starts only after the 16th new sample.
        for (int i = 0; i < N - 1; i++) send_sample(8'd1);
        check("simul_wrptr0", 32'(sample_ready), 32'd1);
        send_sample(8'd1);
        wait_result(cyc);
        check("simul_latency", 32'(cyc), 32'd16);
        check("simul_result", 32'(result), 32'd136);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
